pwm_update_scheduler: RTL



---
 rtl/pwm_update_scheduler_pkg.sv | 31 +++
 rtl/pwm_update_scheduler_carrier_event_detect.sv | 16 +
 rtl/pwm_update_scheduler.sv | 115 +++++++++++
 3 files changed

// File: rtl/pwm_update_scheduler_pkg.sv
// Shared types and widths for the PWM update-commit scheduler.
// The FSM state constants are plain logic so legacy code can compare against them.
package pwm_update_scheduler_pkg;

  localparam int PWMCOUNT_WIDTH = 16;
  localparam int UPDSKIP_WIDTH  = 4;
  localparam int NCH            = 8;

  typedef logic [1:0] upd_mode_t;
  localparam upd_mode_t UPD_IMMEDIATE = 2'd0;
  localparam upd_mode_t UPD_ZERO      = 2'd1;
  localparam upd_mode_t UPD_PEAK      = 2'd2;
  localparam upd_mode_t UPD_BOTH      = 2'd3;

  typedef logic [1:0] upd_state_t;
  localparam upd_state_t ST_OFF    = 2'd0;
  localparam upd_state_t ST_RUN    = 2'd1;
  localparam upd_state_t ST_COMMIT = 2'd2;

  function automatic logic mode_qualifies(upd_mode_t mode, logic zero_hit, logic peak_hit);
    logic hit;
    case (mode)
      UPD_IMMEDIATE: hit = 1'b1;
      UPD_ZERO:      hit = zero_hit;
      UPD_PEAK:      hit = peak_hit;
      default:       hit = zero_hit | peak_hit;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pwm_update_scheduler_carrier_event_detect.sv
// Combinational zero/peak arrival detect for a shared carrier counter.
// Fires only on arrival, so a carrier parked at zero or at the peak gives a single hit.
module carrier_event_detect #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] carrier,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] carrier_q,
  output logic             zero_hit,
  output logic             peak_hit
);

  assign zero_hit = (carrier == '0) && (carrier_q != '0);
  assign peak_hit = (carrier == period) && (carrier_q != period);

endmodule

// File: rtl/pwm_update_scheduler.sv
// Collects per-channel update strobes and commits them to the shadow masks
// as a one-cycle maskevent pulse at the selected carrier event.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_OFF    | carrier stopped; pending bits commit as soon as unlocked
// ST_RUN    | carrier running; wait for a commit slot with work pending
// ST_COMMIT | one cycle: pending snapshot goes out on maskevent next edge
module pwm_update_scheduler #(
  parameter int PWMCOUNT_WIDTH = pwm_update_scheduler_pkg::PWMCOUNT_WIDTH,
  parameter int NCH            = pwm_update_scheduler_pkg::NCH
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [PWMCOUNT_WIDTH-1:0]                         carrier,
  input  logic [PWMCOUNT_WIDTH-1:0]                         period,
  input  logic                                              pwm_onoff,
  input  pwm_update_scheduler_pkg::upd_mode_t               upd_mode,
  input  logic [pwm_update_scheduler_pkg::UPDSKIP_WIDTH-1:0] upd_skip,
  input  logic                                              upd_lock,
  input  logic [NCH-1:0]                                    upd_req,
  output logic [NCH-1:0]                                    pending,
  output logic [NCH-1:0]                                    maskevent,
  output logic                                              evt_zero,
  output logic                                              evt_peak,
  output logic                                              busy
);
  import pwm_update_scheduler_pkg::*;

  logic [PWMCOUNT_WIDTH-1:0] carrier_q;
  logic                      zero_hit;
  logic                      peak_hit;
  logic                      qual;
  logic                      slot;
  upd_state_t                state;
  upd_state_t                state_nxt;
  logic [UPDSKIP_WIDTH-1:0]  skip_cnt;
  logic [UPDSKIP_WIDTH-1:0]  skip_cnt_nxt;

  carrier_event_detect #(
    .WIDTH (PWMCOUNT_WIDTH)
  ) u_evt (
    .carrier   (carrier),
    .period    (period),
    .carrier_q (carrier_q),
    .zero_hit  (zero_hit),
    .peak_hit  (peak_hit)
  );

  // OR-ing the two hits keeps period==0 at one event per cycle in BOTH mode.
  assign qual = mode_qualifies(upd_mode, zero_hit, peak_hit);
  assign busy = |pending;

  // The prescaler keeps counting during the commit cycle so no carrier event is lost.
  always_comb begin
    skip_cnt_nxt = skip_cnt;
    slot         = 1'b0;
    if (state == ST_OFF) begin
      skip_cnt_nxt = upd_skip;
    end else if (qual) begin
      if (upd_mode == UPD_IMMEDIATE) begin
        slot = 1'b1;
      end else if (skip_cnt == '0) begin
        slot         = 1'b1;
        skip_cnt_nxt = upd_skip;
      end else begin
        skip_cnt_nxt = skip_cnt - UPDSKIP_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF: begin
        if (pwm_onoff) begin
          state_nxt = ST_RUN;
        end else if ((|pending) && !upd_lock) begin
          state_nxt = ST_COMMIT;
        end
      end
      ST_RUN: begin
        if (!pwm_onoff) begin
          state_nxt = ST_OFF;
        end else if (slot && (|pending) && !upd_lock) begin
          state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: state_nxt = pwm_onoff ? ST_RUN : ST_OFF;
      default:   state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_OFF;
      skip_cnt  <= '0;
      carrier_q <= '0;
      evt_zero  <= 1'b0;
      evt_peak  <= 1'b0;
      pending   <= '0;
      maskevent <= '0;
    end else begin
      state     <= state_nxt;
      skip_cnt  <= skip_cnt_nxt;
      carrier_q <= carrier;
      evt_zero  <= zero_hit;
      evt_peak  <= peak_hit;
      // A strobe landing in the commit cycle survives for the next slot.
      pending   <= ((state == ST_COMMIT) ? '0 : pending) | upd_req;
      maskevent <= (state == ST_COMMIT) ? pending : '0;
    end
  end

endmodule
